// File: rtl/lfsr_stream_checker.sv
// Self-check stage for a Galois LFSR stream: predicts each sample, flags mismatches and lockup,
// and measures the sequence period as the distance between returns to the first captured value.
module lfsr_stream_checker #(
  parameter int             W      = 4,
  parameter logic [W-1:0]   TAPS   = 4'b1010,
  parameter int             ECW    = 8,
  parameter int             LOSS_N = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic           clear,
  input  logic [W-1:0]   q_in,
  output logic           locked,
  output logic           err,
  output logic [ECW-1:0] err_cnt,
  output logic           lockup,
  output logic [W-1:0]   period,
  output logic           period_valid
);

  localparam int         SW        = (LOSS_N < 2) ? 1 : $clog2(LOSS_N + 1);
  localparam logic [W:0] COUNT_MAX = {1'b1, {W{1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    LOST  = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   seed_q, seed_d;
  logic [W-1:0]   exp_q, exp_d;
  logic [W:0]     count_q, count_d;
  logic [SW-1:0]  streak_q, streak_d;

  logic           locked_d, err_d, lockup_d, period_valid_d;
  logic [ECW-1:0] err_cnt_d;
  logic [W-1:0]   period_d;

  logic [W:0]     count_inc;
  logic [ECW-1:0] err_cnt_inc;
  logic [SW-1:0]  streak_inc;

  // Galois step: shift left, fold the outgoing MSB into every tapped stage.
  function automatic logic [W-1:0] nx(input logic [W-1:0] s);
    logic [W-1:0] r;
    r[0] = s[W-1];
    for (int i = 1; i < W; i++) begin
      r[i] = s[i-1] ^ (TAPS[i] & s[W-1]);
    end
    return r;
  endfunction

  assign count_inc   = (count_q == COUNT_MAX) ? count_q : count_q + 1'b1;
  assign err_cnt_inc = (&err_cnt) ? err_cnt : err_cnt + 1'b1;
  assign streak_inc  = streak_q + 1'b1;

  always_comb begin
    // NOTE: every target gets a hold value first so no path through the block infers a latch.
    state_d        = state_q;
    seed_d         = seed_q;
    exp_d          = exp_q;
    count_d        = count_q;
    streak_d       = streak_q;
    locked_d       = locked;
    err_d          = err;
    err_cnt_d      = err_cnt;
    lockup_d       = lockup;
    period_d       = period;
    period_valid_d = period_valid;

    if (clear) begin
      state_d        = IDLE;
      seed_d         = '0;
      exp_d          = '0;
      count_d        = '0;
      streak_d       = '0;
      locked_d       = 1'b0;
      err_d          = 1'b0;
      err_cnt_d      = '0;
      lockup_d       = 1'b0;
      period_d       = '0;
      period_valid_d = 1'b0;
    end else if (en) begin
      if (q_in == '0) lockup_d = 1'b1;

      unique case (state_q)
        IDLE, LOST: begin
          // A fresh seed invalidates any earlier period measurement.
          seed_d         = q_in;
          exp_d          = nx(q_in);
          count_d        = {{W{1'b0}}, 1'b1};
          streak_d       = '0;
          locked_d       = 1'b0;
          period_valid_d = 1'b0;
          state_d        = TRACK;
        end
        TRACK: begin
          exp_d = nx(q_in);
          if (q_in == exp_q) begin
            locked_d = 1'b1;
            streak_d = '0;
            if (q_in == seed_q) begin
              if (!period_valid) begin
                period_d       = count_q[W-1:0];
                period_valid_d = 1'b1;
              end else if (count_q != {1'b0, period}) begin
                err_d = 1'b1;
              end
              count_d = {{W{1'b0}}, 1'b1};
            end else begin
              count_d = count_inc;
            end
          end else begin
            // Resync on the observed value so a single glitch costs one error, not a cascade.
            locked_d  = 1'b0;
            err_d     = 1'b1;
            err_cnt_d = err_cnt_inc;
            count_d   = count_inc;
            streak_d  = streak_inc;
            if (streak_inc == SW'(LOSS_N)) state_d = LOST;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      // NOTE: registers update with non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seed_q       <= '0;
      exp_q        <= '0;
      count_q      <= '0;
      streak_q     <= '0;
      locked       <= 1'b0;
      err          <= 1'b0;
      err_cnt      <= '0;
      lockup       <= 1'b0;
      period       <= '0;
      period_valid <= 1'b0;
    end else begin
      seed_q       <= seed_d;
      exp_q        <= exp_d;
      count_q      <= count_d;
      streak_q     <= streak_d;
      locked       <= locked_d;
      err          <= err_d;
      err_cnt      <= err_cnt_d;
      lockup       <= lockup_d;
      period       <= period_d;
      period_valid <= period_valid_d;
    end
  end

endmodule
